// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between a requester (IorD/PC stage)
// and the word-wide memory responder.
interface mem_responder_if;
  logic        mem_req;
  logic        mem_w;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] mem_out;
  logic        mem_ready;
  logic        mem_busy;
  logic        mem_err;

  modport master (
    output mem_req, mem_w, addr, wdata,
    input  mem_out, mem_ready, mem_busy, mem_err
  );

  modport slave (
    input  mem_req, mem_w, addr, wdata,
    output mem_out, mem_ready, mem_busy, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-wide memory with a wait-state FSM (IDLE/WAIT/RESP).
// A request is accepted in IDLE, held for WAIT_CYCLES, then the access is
// performed on the edge entering RESP with a one-cycle mem_ready pulse.
// Optional feature macro: MEM_ALIGN_CHECK_EN (reject odd byte addresses
// with a one-cycle mem_err pulse alongside mem_ready, no access performed).
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              reset,
  mem_responder_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WCNT_INIT = 4'(WAIT_CYCLES);

  state_t                 state_q;
  logic [3:0]             wcnt_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [15:0]            wdata_q;
  logic                   w_q;
  logic [15:0]            out_q;
  logic                   ready_q;
  logic                   busy_q;
`ifdef MEM_ALIGN_CHECK_EN
  logic                   err_q;
`endif

  logic [15:0]            mem_q [2**ADDR_BITS];

  logic                   misalign_d;
  logic                   acc_go_d;
  logic [ADDR_BITS-1:0]   acc_idx_d;
  logic                   acc_w_d;
  logic [15:0]            acc_wdata_d;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_d = bus.addr[0];
`else
  assign misalign_d = 1'b0;
`endif

  // Byte address bits outside the word index do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[15:ADDR_BITS+1], bus.addr[0]};

  // Access strobe for the edge entering RESP. With zero wait states that edge
  // is the acceptance edge itself, so the live bus inputs are used instead of
  // the (not yet loaded) latched copies.
  always_comb begin
    acc_go_d    = 1'b0;
    acc_idx_d   = idx_q;
    acc_w_d     = w_q;
    acc_wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.mem_req && (WAIT_CYCLES == 0) && !misalign_d) begin
          acc_go_d    = 1'b1;
          acc_idx_d   = bus.addr[ADDR_BITS:1];
          acc_w_d     = bus.mem_w;
          acc_wdata_d = bus.wdata;
        end
      end
      S_WAIT:  acc_go_d = (wcnt_q == 4'd1);
      default: ;
    endcase
  end

  // Write commit; reset on the same edge aborts the transaction.
  always_ff @(posedge CLK) begin
    if (!reset && acc_go_d && acc_w_d) begin
      mem_q[acc_idx_d] <= acc_wdata_d;
    end
  end

  // Wait-state FSM with registered outputs and read-data capture.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      w_q     <= 1'b0;
      out_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
      if (acc_go_d && !acc_w_d) begin
        out_q <= mem_q[acc_idx_d];
      end
      case (state_q)
        S_IDLE: begin
          if (bus.mem_req) begin
            idx_q   <= bus.addr[ADDR_BITS:1];
            wdata_q <= bus.wdata;
            w_q     <= bus.mem_w;
            busy_q  <= 1'b1;
            if (misalign_d) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
              err_q   <= 1'b1;
`endif
            end else if (WAIT_CYCLES == 0) begin
              state_q <= S_RESP;
              ready_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              wcnt_q  <= WCNT_INIT;
            end
          end
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_out   = out_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_busy  = busy_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign bus.mem_err   = err_q;
`else
  assign bus.mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder with three instances
// (WAIT_CYCLES = 1, 0, 3). A scoreboard queue holds expected responses pushed
// at request time and popped when mem_ready is observed.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        w;
  logic [15:0] a;
  logic [15:0] d;
  int          sel;

  always #5 clk = ~clk;

  mem_responder_if b0 ();
  mem_responder_if b1 ();
  mem_responder_if b2 ();

  assign b0.mem_req = req && (sel == 0);
  assign b1.mem_req = req && (sel == 1);
  assign b2.mem_req = req && (sel == 2);
  assign b0.mem_w = w;  assign b0.addr = a;  assign b0.wdata = d;
  assign b1.mem_w = w;  assign b1.addr = a;  assign b1.wdata = d;
  assign b2.mem_w = w;  assign b2.addr = a;  assign b2.wdata = d;

  mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(1)) u0 (.CLK(clk), .reset(rst), .bus(b0));
  mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) u1 (.CLK(clk), .reset(rst), .bus(b1));
  mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(3)) u2 (.CLK(clk), .reset(rst), .bus(b2));

  logic [15:0] o_out;
  logic        o_rdy, o_busy, o_err;

  always_comb begin
    o_out = b0.mem_out; o_rdy = b0.mem_ready; o_busy = b0.mem_busy; o_err = b0.mem_err;
    case (sel)
      1: begin o_out = b1.mem_out; o_rdy = b1.mem_ready; o_busy = b1.mem_busy; o_err = b1.mem_err; end
      2: begin o_out = b2.mem_out; o_rdy = b2.mem_ready; o_busy = b2.mem_busy; o_err = b2.mem_err; end
      default: ;
    endcase
  end

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mdl [int];
  logic [15:0] last_out [3];
  int          checks = 0;
  int          errors = 0;

  function automatic int wc_of(input int s);
    return (s == 0) ? 1 : (s == 1) ? 0 : 3;
  endfunction

  function automatic int key(input int s, input logic [15:0] ad);
    return s * 4096 + int'(ad[10:1]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s sel=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic pop_and_check(input int k);
    exp_t e;
    if (o_rdy === 1'b1 && sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rdata", 32'(o_out), 32'(e.data));
      chk("latency", 32'(k), 32'(e.due));
    end
  endtask

  // One complete transaction with per-cycle checks until the FSM is idle.
  task automatic xact(input logic wr, input logic [15:0] ad, input logic [15:0] dat);
    exp_t e;
    bit   mis;
    int   due;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = ad[0];
`endif
    due = mis ? 1 : 1 + wc_of(sel);
    @(negedge clk);
    req = 1'b1; w = wr; a = ad; d = dat;
    e.due = due;
    if (mis || wr) e.data = last_out[sel];
    else           e.data = mdl[key(sel, ad)];
    if (!mis && !wr) last_out[sel] = e.data;
    if (!mis && wr)  mdl[key(sel, ad)] = dat;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    req = 1'b0; a = ~ad; d = ~dat; w = ~wr;
    for (int k = 1; k <= due + 1; k++) begin
      @(negedge clk);
      chk("busy",  32'(o_busy), 32'(k <= due));
      chk("ready", 32'(o_rdy),  32'(k == due));
      chk("err",   32'(o_err),  32'(mis && (k == due)));
      pop_and_check(k);
    end
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  initial begin
    exp_t e;
    sel = 0; rst = 1'b1; req = 1'b1; w = 1'b0; a = '0; d = '0;
    for (int s = 0; s < 3; s++) last_out[s] = '0;

    // Reset held two edges with mem_req high on the selected instance.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_out",   32'(o_out),  32'd0);
      chk("rst_ready", 32'(o_rdy),  32'd0);
      chk("rst_busy",  32'(o_busy), 32'd0);
      chk("rst_err",   32'(o_err),  32'd0);
    end
    sel = 0; rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(o_busy), 32'd0);

    // WAIT_CYCLES = 1: write/read, wrap-around, odd address.
    sel = 0;
    xact(1'b1, 16'h0010, 16'hBEEF);
    xact(1'b0, 16'h0010, 16'h0000);
    xact(1'b1, 16'h0802, 16'h1234);
    xact(1'b0, 16'h0002, 16'h0000);
    xact(1'b1, 16'h0011, 16'hAAAA);
    xact(1'b0, 16'h0010, 16'h0000);

    // WAIT_CYCLES = 0: back-to-back reads accepted every 2 cycles.
    sel = 1;
    xact(1'b1, 16'h0040, 16'h1111);
    xact(1'b1, 16'h0042, 16'h2222);
    @(negedge clk);
    req = 1'b1; w = 1'b0; a = 16'h0040;
    e.data = 16'h1111; e.due = 1; sbq.push_back(e);
    e.data = 16'h2222; e.due = 3; sbq.push_back(e);
    last_out[1] = 16'h2222;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(o_rdy),  32'((k == 1) || (k == 3)));
      chk("b2b_busy",  32'(o_busy), 32'((k == 1) || (k == 3)));
      pop_and_check(k);
      if (k == 1) a = 16'h0042;
      if (k == 3) req = 1'b0;
    end
    chk("b2b_sb_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();

    // WAIT_CYCLES = 0: request pulse during RESP is ignored.
    @(negedge clk);
    req = 1'b1; w = 1'b0; a = 16'h0040;
    e.data = 16'h1111; e.due = 1; sbq.push_back(e);
    last_out[1] = 16'h1111;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("resp_ready", 32'(o_rdy), 32'd1);
    pop_and_check(1);
    req = 1'b1; a = 16'h0042;
    @(posedge clk);
    #1 req = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      chk("ign_ready", 32'(o_rdy),  32'd0);
      chk("ign_busy",  32'(o_busy), 32'd0);
      chk("ign_out",   32'(o_out),  32'h1111);
    end
    chk("ign_sb_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();

    // WAIT_CYCLES = 3: reset in cycle 2 aborts a pending write.
    sel = 2;
    xact(1'b1, 16'h0020, 16'h0000);
    @(negedge clk);
    req = 1'b1; w = 1'b1; a = 16'h0020; d = 16'h5555;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("abort_busy1", 32'(o_busy), 32'd1);
    chk("abort_ready1", 32'(o_rdy), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) last_out[s] = '0;
    chk("abort_busy_rst", 32'(o_busy), 32'd0);
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      chk("abort_ready", 32'(o_rdy),  32'd0);
      chk("abort_busy",  32'(o_busy), 32'd0);
    end
    xact(1'b0, 16'h0020, 16'h0000);

    // Array contents survive reset.
    sel = 0;
    xact(1'b0, 16'h0002, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-wide memory responder for the 16-bit multicycle datapath. It receives the address the IorD mux selects, along with a read/write request. It runs a small wait-state FSM, then either commits the write or returns read data on `mem_out`, marking completion with a one-cycle `mem_ready` pulse. The PC/IorD stage uses `mem_out` as its memory-return input.

## Interface
Parameters:
- `ADDR_BITS`, default 10: log2 of the number of 16-bit words in the array.
- `WAIT_CYCLES`, default 1, range 0..15: extra cycles spent between accepting a request and responding.

Ports:
- `CLK`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `mem_req`  in  1  request strobe, sampled only in IDLE
- `mem_w`  in  1  1 = write, 0 = read
- `addr`  in  16  byte address, driven from the IorD mux output
- `wdata`  in  16  write data
- `mem_out`  out  16  read data; holds the last read value
- `mem_ready`  out  1  one-cycle completion pulse
- `mem_busy`  out  1  high whenever the FSM is not in IDLE
- `mem_err`  out  1  one-cycle misalignment pulse (see Configuration)

## Operation
- Array of 2^ADDR_BITS words, indexed by `addr[ADDR_BITS:1]`. Higher address bits are ignored, so addresses wrap modulo the array size.
- FSM states: IDLE, WAIT, RESP.
- IDLE
  - On `mem_req` = 1: latch `addr`, `wdata` and `mem_w`.
  - If WAIT_CYCLES > 0: load `wcnt` = WAIT_CYCLES and go to WAIT.
  - Otherwise go to RESP.
- WAIT
  - Decrement `wcnt` each cycle.
  - When `wcnt` = 1, go to RESP.
- RESP
  - At the edge entering RESP, the access is performed:
    - Write: array[idx] <= latched wdata; `mem_out` unchanged.
    - Read: `mem_out` <= array[idx].
  - `mem_ready` is registered high at that same edge.
  - The next state is always IDLE.
- Requests arriving while `mem_busy` is high are ignored. They are not queued, and the requester must hold or re-issue them.
- Latched address and data are fixed for the whole transaction. Input changes after acceptance have no effect.
- Read-after-write: a read accepted after the write's `mem_ready` cycle returns the new data.
- Arithmetic: `wcnt` is 4 bits and never underflows, because it leaves WAIT at 1.

## Timing
- Request sampled at edge N.
- Response cycle is N+1+WAIT_CYCLES. `mem_ready` = 1 and `mem_out` is valid in that cycle.
- Write commit happens on that same edge.
- `mem_busy` is high from cycle N+1 through the response cycle inclusive.
- Earliest next acceptance is edge N+2+WAIT_CYCLES. Throughput is one access per WAIT_CYCLES+2 cycles.
- Reset values: state IDLE, `mem_out` 0, `mem_ready` 0, `mem_busy` 0, `mem_err` 0, `wcnt` 0.
- Array contents are not cleared by reset.
- Reset has priority over every other event at the same edge.
- Reset asserted during WAIT, or at the edge that would enter RESP: the transaction is aborted and no write is committed.
- `mem_req` high on the reset edge is not accepted.

## Configuration
Macro `MEM_ALIGN_CHECK_EN`:
- Defined:
  - An accepted request with `addr[0]` = 1 is rejected.
  - The FSM goes straight to RESP regardless of WAIT_CYCLES.
  - `mem_ready` and `mem_err` both pulse high in cycle N+1.
  - No write is performed and `mem_out` is unchanged.
- Undefined:
  - `addr[0]` is ignored.
  - `mem_err` is tied to 0.
  - No alignment logic is present.

## Test plan
- **Reset.** Assert `reset` for 2 cycles.
  - All outputs read 0 and `mem_busy` is 0.
  - `mem_req` held high during reset is not accepted.
- **Write then read, WAIT_CYCLES = 1.** Write 16'hBEEF to addr 16'h0010 at edge 0, then read addr 16'h0010.
  - Write: `mem_ready` pulses in cycle 2 and `mem_busy` is high in cycles 1-2.
  - Read: `mem_out` = 16'hBEEF with `mem_ready` in its response cycle.
- **Wrap-around, ADDR_BITS = 10.** Write 16'h1234 to addr 16'h0802, then read addr 16'h0002.
  - Read returns 16'h1234.
- **Busy drop and zero wait, WAIT_CYCLES = 0.**
  - Back-to-back reads are accepted every 2 cycles.
  - A `mem_req` pulse during the RESP cycle is ignored: no second `mem_ready` and no state change.
- **Reset mid-transaction.** Issue a write of 16'h5555 to addr 16'h0020 (holding 16'h0000) with WAIT_CYCLES = 3. Assert reset in cycle 2.
  - No `mem_ready` is produced.
  - A subsequent read of 16'h0020 returns 16'h0000.
- **Misaligned access, `MEM_ALIGN_CHECK_EN` defined.** Write to addr 16'h0011.
  - `mem_err` and `mem_ready` pulse in cycle 1.
  - A read of 16'h0010 is unchanged.
  - With the macro undefined, the same write lands at word 8 and `mem_err` stays 0.
